alu_rs: RTL and testbench
=========================

# alu_rs

Reservation station for the ALU in the out-of-order core. Receives decoded integer, branch and jump instructions from dispatch and holds them until both source operands are available. Operands are captured from dispatch-time register/ROB values or from common-data-bus (CDB) broadcasts. Issues at most one ready instruction per cycle into the ALU's registered input port.

## Interface
Parameters
- RS_SIZE, 16, number of entries (power of two, 2..32)
- RS_IDX_WID, 4, log2(RS_SIZE)
- ROB_ID_W, 4, ROB tag width (matches shared ROB_ID_WID)

Ports
- clk  in  1  clock
- rst_n  in  1  reset, synchronous, active-low
- rdy  in  1  global enable; low freezes all state
- rollback  in  1  misprediction flush
- in_valid  in  1  dispatch request
- in_opcode / in_func3 / in_func1  in  7/3/1  decoded fields
- in_q1_rdy, in_q2_rdy  in  1  operand already resolved (dispatch sets 1 for unused operands)
- in_v1, in_v2  in  32  operand values when ready
- in_q1, in_q2  in  ROB_ID_W  producer ROB tag when not ready
- in_imm, in_off  in  32  immediate, branch/jump offset
- in_pc  in  32  instruction PC
- in_rob_target  in  ROB_ID_W  destination ROB tag
- in_is_c_extend  in  1  compressed instruction
- full  out  1  no free entry
- cdb_alu_valid, cdb_alu_rob, cdb_alu_data  in  1/ROB_ID_W/32  ALU result broadcast
- cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_data  in  1/ROB_ID_W/32  load result broadcast
- alu_inst_valid  out  1  issue strobe to ALU
- alu_opcode, alu_func3, alu_func1, alu_data1, alu_data2, alu_imm, alu_off, alu_pc, alu_rob_target, alu_is_c_extend  out  matching widths  issued instruction

## Operation
- Entry state per slot: busy, q1_rdy, q2_rdy, v1, v2, q1, q2, plus instruction fields.
- Dispatch: when in_valid && !full, the lowest-index free slot is written, busy=1.
- Dispatch forwarding: if an operand is not ready and its tag matches a same-cycle CDB broadcast, the entry is written with that data and marked ready.
- Snoop: every cycle each busy entry with an unready operand whose tag matches a valid CDB source captures the data and sets ready. ALU CDB takes precedence if both match (cannot occur legally).
- Select: entries with busy && q1_rdy && q2_rdy are eligible. One is chosen; its fields are registered onto alu_* outputs with alu_inst_valid=1, and the slot is freed in the same edge.
- No eligible entry: alu_inst_valid=0 and the other alu_* outputs hold their previous values.
- full is combinational: all slots busy. A dispatch while full is a protocol violation; the bench asserts on it.
- Freed slot is reusable for dispatch in the next cycle, not the same cycle.

## Timing
- Reset (rst_n=0 at posedge) or rollback=1: all busy=0 and alu_inst_valid=0; alu_* data outputs are 0; full=0. Rollback has priority over a same-cycle dispatch or issue, and that instruction is dropped.
- rdy=0: no state or output changes; CDB inputs are ignored that cycle.
- Dispatch at edge t with operands ready → issued at edge t+1 at the earliest → ALU result at edge t+2.
- CDB capture at edge t → eligible for selection in the cycle after t, issued at edge t+1.
- Dispatch with operand forwarded from the CDB at edge t → issued at edge t+1.
- Throughput: one issue per cycle.

## Configuration
- ALU_RS_OLDEST_FIRST_EN defined: each entry stores a dispatch sequence number (RS_IDX_WID+1 bits, wrap-around compared). Select picks the oldest eligible entry.
- ALU_RS_OLDEST_FIRST_EN not defined: select picks the lowest-index eligible entry, and no sequence storage is built.

## Structure
- Shared const package/header holds OPCODE_*, FUNC3_*, DATA_WID, ADDR_WID, ROB_ID_WID.
- Sub-module rs_select (priority/age picker over RS_SIZE ready bits) returns a valid flag and an index. It is reused by the load-store buffer.

## Test plan
- Reset/rollback: fill 3 entries, then pulse rollback → next cycle full=0, alu_inst_valid=0, and nothing issues afterwards.
- Ready dispatch: ADD with v1=5, v2=7, both ready, rob=3 → one cycle later alu_inst_valid=1, alu_data1=5, alu_data2=7, alu_rob_target=3.
- Wakeup: dispatch SUB with q1=tag 6 unready; then cdb_alu_valid with rob=6, data=0x10 → issue on the next edge with alu_data1=0x10.
- Same-cycle forward: dispatch with q2=tag 2 while cdb_lsb broadcasts rob=2, data=0xABCD → issued the next edge with alu_data2=0xABCD.
- Full: dispatch 16 unready instructions → full=1; wake one → it issues, full=0 the next cycle, and a new dispatch is accepted.
- Priority (macro defined): dispatch A then B, both unready; wake B then A in the same cycle → A issues before B. Without the macro, lower index issues first.

Source files
------------

// File: rtl/alu_rs_pkg.sv
// alu_rs_pkg: shared core constants and the instruction bundle held per slot
// in the ALU reservation station.
package alu_rs_pkg;

  localparam int DATA_WID   = 32;
  localparam int ADDR_WID   = 32;
  localparam int ROB_ID_WID = 4;

  localparam logic [6:0] OPCODE_LUI   = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL   = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR  = 7'b1100111;
  localparam logic [6:0] OPCODE_BR    = 7'b1100011;
  localparam logic [6:0] OPCODE_ARITHI = 7'b0010011;
  localparam logic [6:0] OPCODE_ARITH = 7'b0110011;

  localparam logic [2:0] FUNC3_ADD_SUB = 3'd0;
  localparam logic [2:0] FUNC3_SLL     = 3'd1;
  localparam logic [2:0] FUNC3_SLT     = 3'd2;
  localparam logic [2:0] FUNC3_SLTU    = 3'd3;
  localparam logic [2:0] FUNC3_XOR     = 3'd4;
  localparam logic [2:0] FUNC3_SRL_SRA = 3'd5;
  localparam logic [2:0] FUNC3_OR      = 3'd6;
  localparam logic [2:0] FUNC3_AND     = 3'd7;

  typedef struct packed {
    logic [6:0]          opcode;
    logic [2:0]          func3;
    logic                func1;
    logic [DATA_WID-1:0] imm;
    logic [DATA_WID-1:0] off;
    logic [ADDR_WID-1:0] pc;
    logic                is_c;
  } rs_inst_t;

endpackage

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, CDB snoop and ALU issue signals of the ALU
// reservation station. master = dispatch/CDB side, slave = the station.
interface alu_rs_if
  import alu_rs_pkg::*;
#(
  parameter int ROB_ID_W = 4
);

  logic                in_valid;
  logic [6:0]          in_opcode;
  logic [2:0]          in_func3;
  logic                in_func1;
  logic                in_q1_rdy;
  logic                in_q2_rdy;
  logic [DATA_WID-1:0] in_v1;
  logic [DATA_WID-1:0] in_v2;
  logic [ROB_ID_W-1:0] in_q1;
  logic [ROB_ID_W-1:0] in_q2;
  logic [DATA_WID-1:0] in_imm;
  logic [DATA_WID-1:0] in_off;
  logic [ADDR_WID-1:0] in_pc;
  logic [ROB_ID_W-1:0] in_rob_target;
  logic                in_is_c_extend;
  logic                full;

  logic                cdb_alu_valid;
  logic [ROB_ID_W-1:0] cdb_alu_rob;
  logic [DATA_WID-1:0] cdb_alu_data;
  logic                cdb_lsb_valid;
  logic [ROB_ID_W-1:0] cdb_lsb_rob;
  logic [DATA_WID-1:0] cdb_lsb_data;

  logic                alu_inst_valid;
  logic [6:0]          alu_opcode;
  logic [2:0]          alu_func3;
  logic                alu_func1;
  logic [DATA_WID-1:0] alu_data1;
  logic [DATA_WID-1:0] alu_data2;
  logic [DATA_WID-1:0] alu_imm;
  logic [DATA_WID-1:0] alu_off;
  logic [ADDR_WID-1:0] alu_pc;
  logic [ROB_ID_W-1:0] alu_rob_target;
  logic                alu_is_c_extend;

  modport master (
    output in_valid, in_opcode, in_func3, in_func1,
    output in_q1_rdy, in_q2_rdy, in_v1, in_v2,
    output in_q1, in_q2, in_imm, in_off, in_pc,
    output in_rob_target, in_is_c_extend,
    output cdb_alu_valid, cdb_alu_rob, cdb_alu_data,
    output cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_data,
    input  full,
    input  alu_inst_valid, alu_opcode, alu_func3,
    input  alu_func1, alu_data1, alu_data2, alu_imm,
    input  alu_off, alu_pc, alu_rob_target,
    input  alu_is_c_extend
  );

  modport slave (
    input  in_valid, in_opcode, in_func3, in_func1,
    input  in_q1_rdy, in_q2_rdy, in_v1, in_v2,
    input  in_q1, in_q2, in_imm, in_off, in_pc,
    input  in_rob_target, in_is_c_extend,
    input  cdb_alu_valid, cdb_alu_rob, cdb_alu_data,
    input  cdb_lsb_valid, cdb_lsb_rob, cdb_lsb_data,
    output full,
    output alu_inst_valid, alu_opcode, alu_func3,
    output alu_func1, alu_data1, alu_data2, alu_imm,
    output alu_off, alu_pc, alu_rob_target,
    output alu_is_c_extend
  );

endinterface

// File: rtl/rs_select.sv
// rs_select: picks one requesting slot. Lowest index by default; oldest
// by wrap-around sequence number when ALU_RS_OLDEST_FIRST_EN is defined.
module rs_select #(
  parameter int N     = 16,
  parameter int IDX_W = 4
`ifdef ALU_RS_OLDEST_FIRST_EN
  ,
  parameter int SEQ_W = IDX_W + 1
`endif
) (
  input  logic [N-1:0]     i_req,
`ifdef ALU_RS_OLDEST_FIRST_EN
  input  logic [SEQ_W-1:0] i_seq [N],
  input  logic [SEQ_W-1:0] i_now,
`endif
  output logic             o_valid,
  output logic [IDX_W-1:0] o_idx
);

`ifdef ALU_RS_OLDEST_FIRST_EN
  // age = distance back from the next sequence number; larger is older
  always_comb begin
    logic [SEQ_W-1:0] w_age;
    logic [SEQ_W-1:0] w_best;
    o_valid = 1'b0;
    o_idx   = '0;
    w_age   = '0;
    w_best  = '0;
    for (int i = 0; i < N; i++) begin
      w_age = i_now - i_seq[i];
      if (i_req[i] && (!o_valid || w_age > w_best)) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
        w_best  = w_age;
      end
    end
  end
`else
  always_comb begin
    o_valid = 1'b0;
    o_idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (i_req[i]) begin
        o_valid = 1'b1;
        o_idx   = IDX_W'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station with CDB snoop and single issue per cycle.
// Define ALU_RS_OLDEST_FIRST_EN for oldest-first select (else lowest index).
module alu_rs
  import alu_rs_pkg::*;
#(
  parameter int RS_SIZE    = 16,
  parameter int RS_IDX_WID = 4,
  parameter int ROB_ID_W   = 4
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     rdy,
  input  logic     rollback,
  alu_rs_if.slave  bus
);

  logic [RS_SIZE-1:0]  r_busy;
  logic [RS_SIZE-1:0]  r_q1_rdy;
  logic [RS_SIZE-1:0]  r_q2_rdy;
  logic [DATA_WID-1:0] r_v1  [RS_SIZE];
  logic [DATA_WID-1:0] r_v2  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q1  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_q2  [RS_SIZE];
  logic [ROB_ID_W-1:0] r_rob [RS_SIZE];
  rs_inst_t            r_inst [RS_SIZE];

  logic                r_alu_valid;
  rs_inst_t            r_alu_inst;
  logic [DATA_WID-1:0] r_alu_d1;
  logic [DATA_WID-1:0] r_alu_d2;
  logic [ROB_ID_W-1:0] r_alu_rob;

  logic                  w_full;
  logic                  w_disp;
  logic [RS_IDX_WID-1:0] w_free_idx;
  logic [RS_SIZE-1:0]    w_req;
  logic                  w_sel_valid;
  logic [RS_IDX_WID-1:0] w_sel_idx;
  logic                  w_f1_alu, w_f1_lsb;
  logic                  w_f2_alu, w_f2_lsb;
  logic                  w_d_q1_rdy, w_d_q2_rdy;
  logic [DATA_WID-1:0]   w_d_v1, w_d_v2;
  rs_inst_t              w_d_inst;

  assign w_full = &r_busy;
  assign w_disp = bus.in_valid & ~w_full;
  assign w_req  = r_busy & r_q1_rdy & r_q2_rdy;

  always_comb begin
    w_free_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (!r_busy[i]) w_free_idx = RS_IDX_WID'(i);
    end
  end

  // same-cycle CDB forwarding into the slot being written
  assign w_f1_alu = bus.cdb_alu_valid &&
                    bus.cdb_alu_rob == bus.in_q1;
  assign w_f1_lsb = bus.cdb_lsb_valid &&
                    bus.cdb_lsb_rob == bus.in_q1;
  assign w_f2_alu = bus.cdb_alu_valid &&
                    bus.cdb_alu_rob == bus.in_q2;
  assign w_f2_lsb = bus.cdb_lsb_valid &&
                    bus.cdb_lsb_rob == bus.in_q2;

  assign w_d_q1_rdy = bus.in_q1_rdy | w_f1_alu | w_f1_lsb;
  assign w_d_q2_rdy = bus.in_q2_rdy | w_f2_alu | w_f2_lsb;

  assign w_d_v1 = bus.in_q1_rdy ? bus.in_v1 :
                  w_f1_alu      ? bus.cdb_alu_data :
                                  bus.cdb_lsb_data;
  assign w_d_v2 = bus.in_q2_rdy ? bus.in_v2 :
                  w_f2_alu      ? bus.cdb_alu_data :
                                  bus.cdb_lsb_data;

  assign w_d_inst = '{
    opcode: bus.in_opcode,
    func3:  bus.in_func3,
    func1:  bus.in_func1,
    imm:    bus.in_imm,
    off:    bus.in_off,
    pc:     bus.in_pc,
    is_c:   bus.in_is_c_extend
  };

`ifdef ALU_RS_OLDEST_FIRST_EN
  localparam int SEQ_W = RS_IDX_WID + 1;
  logic [SEQ_W-1:0] r_seq [RS_SIZE];
  logic [SEQ_W-1:0] r_seq_now;

  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_WID),
    .SEQ_W (SEQ_W)
  ) u_sel (
    .i_req   (w_req),
    .i_seq   (r_seq),
    .i_now   (r_seq_now),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n || (rdy && rollback)) begin
      r_seq_now <= '0;
    end else if (rdy && w_disp) begin
      r_seq[w_free_idx] <= r_seq_now;
      r_seq_now         <= r_seq_now + 1'b1;
    end
  end
`else
  rs_select #(
    .N     (RS_SIZE),
    .IDX_W (RS_IDX_WID)
  ) u_sel (
    .i_req   (w_req),
    .o_valid (w_sel_valid),
    .o_idx   (w_sel_idx)
  );
`endif

  always_ff @(posedge clk) begin
    if (!rst_n || (rdy && rollback)) begin
      r_busy      <= '0;
      r_alu_valid <= 1'b0;
      r_alu_inst  <= '0;
      r_alu_d1    <= '0;
      r_alu_d2    <= '0;
      r_alu_rob   <= '0;
    end else if (rdy) begin
      // snoop: ALU CDB wins over LSB CDB
      for (int i = 0; i < RS_SIZE; i++) begin
        if (r_busy[i] && !r_q1_rdy[i]) begin
          if (bus.cdb_alu_valid && r_q1[i] == bus.cdb_alu_rob) begin
            r_q1_rdy[i] <= 1'b1;
            r_v1[i]     <= bus.cdb_alu_data;
          end else if (bus.cdb_lsb_valid &&
                       r_q1[i] == bus.cdb_lsb_rob) begin
            r_q1_rdy[i] <= 1'b1;
            r_v1[i]     <= bus.cdb_lsb_data;
          end
        end
        if (r_busy[i] && !r_q2_rdy[i]) begin
          if (bus.cdb_alu_valid && r_q2[i] == bus.cdb_alu_rob) begin
            r_q2_rdy[i] <= 1'b1;
            r_v2[i]     <= bus.cdb_alu_data;
          end else if (bus.cdb_lsb_valid &&
                       r_q2[i] == bus.cdb_lsb_rob) begin
            r_q2_rdy[i] <= 1'b1;
            r_v2[i]     <= bus.cdb_lsb_data;
          end
        end
      end

      if (w_disp) begin
        r_busy[w_free_idx]   <= 1'b1;
        r_q1_rdy[w_free_idx] <= w_d_q1_rdy;
        r_q2_rdy[w_free_idx] <= w_d_q2_rdy;
        r_v1[w_free_idx]     <= w_d_v1;
        r_v2[w_free_idx]     <= w_d_v2;
        r_q1[w_free_idx]     <= bus.in_q1;
        r_q2[w_free_idx]     <= bus.in_q2;
        r_rob[w_free_idx]    <= bus.in_rob_target;
        r_inst[w_free_idx]   <= w_d_inst;
      end

      r_alu_valid <= w_sel_valid;
      if (w_sel_valid) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_alu_inst        <= r_inst[w_sel_idx];
        r_alu_d1          <= r_v1[w_sel_idx];
        r_alu_d2          <= r_v2[w_sel_idx];
        r_alu_rob         <= r_rob[w_sel_idx];
      end
    end
  end

  assign bus.full            = w_full;
  assign bus.alu_inst_valid  = r_alu_valid;
  assign bus.alu_opcode      = r_alu_inst.opcode;
  assign bus.alu_func3       = r_alu_inst.func3;
  assign bus.alu_func1       = r_alu_inst.func1;
  assign bus.alu_data1       = r_alu_d1;
  assign bus.alu_data2       = r_alu_d2;
  assign bus.alu_imm         = r_alu_inst.imm;
  assign bus.alu_off         = r_alu_inst.off;
  assign bus.alu_pc          = r_alu_inst.pc;
  assign bus.alu_rob_target  = r_alu_rob;
  assign bus.alu_is_c_extend = r_alu_inst.is_c;

endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: directed table, corner sequences and random traffic for alu_rs,
// checked against an entry-list model of the reservation station.
module tb_alu_rs;
  import alu_rs_pkg::*;

  localparam int N = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b1;
  logic rollback = 1'b0;

  always #5 clk = ~clk;

  alu_rs_if #(.ROB_ID_W(4)) bus ();

  alu_rs #(
    .RS_SIZE    (16),
    .RS_IDX_WID (4),
    .ROB_ID_W   (4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus)
  );

  typedef struct {
    bit          busy;
    bit          r1, r2;
    logic [31:0] v1, v2;
    logic [3:0]  q1, q2;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f1;
    logic [31:0] imm, off, pc;
    logic [3:0]  rob;
    logic        c;
    int unsigned seq;
  } ment_t;

  ment_t       m [N];
  ment_t       e;
  logic        e_valid;
  int unsigned m_seq;
  int          n_cmp = 0;
  int          n_bad = 0;

  function automatic int m_cnt();
    int k = 0;
    for (int i = 0; i < N; i++) if (m[i].busy) k++;
    return k;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_clear();
    for (int i = 0; i < N; i++) m[i].busy = 0;
    e_valid = 0;
    e = '{default: '0};
    m_seq = 0;
  endtask

  task automatic m_cap(input int i, input bit second);
    logic [3:0] q = second ? m[i].q2 : m[i].q1;
    logic [31:0] d;
    bit hit = 0;
    if (bus.cdb_alu_valid && bus.cdb_alu_rob == q) begin
      hit = 1; d = bus.cdb_alu_data;
    end else if (bus.cdb_lsb_valid && bus.cdb_lsb_rob == q) begin
      hit = 1; d = bus.cdb_lsb_data;
    end
    if (hit && second) begin m[i].r2 = 1; m[i].v2 = d; end
    if (hit && !second) begin m[i].r1 = 1; m[i].v1 = d; end
  endtask

  // one clock edge as seen by the spec's rules
  task automatic m_edge();
    int pick = -1;
    if (!rst_n || (rdy && rollback)) begin
      m_clear();
      return;
    end
    if (!rdy) return;
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && m[i].r1 && m[i].r2) begin
`ifdef ALU_RS_OLDEST_FIRST_EN
        if (pick < 0 || m[i].seq < m[pick].seq) pick = i;
`else
        if (pick < 0) pick = i;
`endif
      end
    end
    e_valid = (pick >= 0);
    if (pick >= 0) e = m[pick];
    for (int i = 0; i < N; i++) begin
      if (m[i].busy && !m[i].r1) m_cap(i, 0);
      if (m[i].busy && !m[i].r2) m_cap(i, 1);
    end
    if (bus.in_valid && m_cnt() < N) begin
      int k = 0;
      while (m[k].busy) k++;
      m[k] = '{busy: 1, r1: bus.in_q1_rdy, r2: bus.in_q2_rdy,
               v1: bus.in_v1, v2: bus.in_v2,
               q1: bus.in_q1, q2: bus.in_q2,
               op: bus.in_opcode, f3: bus.in_func3,
               f1: bus.in_func1, imm: bus.in_imm,
               off: bus.in_off, pc: bus.in_pc,
               rob: bus.in_rob_target, c: bus.in_is_c_extend,
               seq: m_seq};
      m_seq++;
      if (!m[k].r1) m_cap(k, 0);
      if (!m[k].r2) m_cap(k, 1);
    end
    if (pick >= 0) m[pick].busy = 0;
  endtask

  always @(posedge clk) begin
    assert (!(bus.in_valid && bus.full))
      else $error("dispatch while full");
  end

  task automatic step();
    @(posedge clk);
    m_edge();
    #1;
    chk("valid", 32'(bus.alu_inst_valid), 32'(e_valid));
    chk("opcode", 32'(bus.alu_opcode), 32'(e.op));
    chk("func3", 32'(bus.alu_func3), 32'(e.f3));
    chk("func1", 32'(bus.alu_func1), 32'(e.f1));
    chk("data1", bus.alu_data1, e.v1);
    chk("data2", bus.alu_data2, e.v2);
    chk("imm", bus.alu_imm, e.imm);
    chk("off", bus.alu_off, e.off);
    chk("pc", bus.alu_pc, e.pc);
    chk("rob", 32'(bus.alu_rob_target), 32'(e.rob));
    chk("is_c", 32'(bus.alu_is_c_extend), 32'(e.c));
    chk("full", 32'(bus.full), 32'(m_cnt() == N));
  endtask

  task automatic idle();
    bus.in_valid = 0;
    bus.cdb_alu_valid = 0;
    bus.cdb_lsb_valid = 0;
  endtask

  task automatic disp(input logic [6:0] op, input logic [2:0] f3,
                      input logic r1, input logic [31:0] v1,
                      input logic [3:0] q1, input logic r2,
                      input logic [31:0] v2, input logic [3:0] q2,
                      input logic [3:0] rob, input logic [31:0] pc);
    bus.in_valid = 1;
    bus.in_opcode = op;
    bus.in_func3 = f3;
    bus.in_func1 = pc[2];
    bus.in_q1_rdy = r1;
    bus.in_v1 = v1;
    bus.in_q1 = q1;
    bus.in_q2_rdy = r2;
    bus.in_v2 = v2;
    bus.in_q2 = q2;
    bus.in_imm = pc ^ 32'h0000_0F0F;
    bus.in_off = pc + 32'd8;
    bus.in_pc = pc;
    bus.in_rob_target = rob;
    bus.in_is_c_extend = pc[1];
  endtask

  task automatic cdb_alu(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_alu_valid = 1; bus.cdb_alu_rob = t; bus.cdb_alu_data = d;
  endtask

  task automatic cdb_lsb(input logic [3:0] t, input logic [31:0] d);
    bus.cdb_lsb_valid = 1; bus.cdb_lsb_rob = t; bus.cdb_lsb_data = d;
  endtask

  task automatic flush();
    idle();
    rollback = 1;
    step();
    rollback = 0;
  endtask

  typedef struct {
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [31:0] v1, v2, pc;
    logic [3:0]  rob;
    logic [31:0] x_d1, x_d2;
    logic [3:0]  x_rob;
  } vec_t;

  vec_t tv [4];
  logic [3:0] first_rob;

  initial begin
    tv[0] = '{OPCODE_ARITH, FUNC3_ADD_SUB, 32'd5, 32'd7,
              32'h1000, 4'd3, 32'd5, 32'd7, 4'd3};
    tv[1] = '{OPCODE_ARITHI, FUNC3_XOR, 32'hFFFF_FFFF, 32'h0,
              32'h2004, 4'd0, 32'hFFFF_FFFF, 32'h0, 4'd0};
    tv[2] = '{OPCODE_BR, FUNC3_SLT, 32'h8000_0000, 32'h7FFF_FFFF,
              32'h3002, 4'd15, 32'h8000_0000, 32'h7FFF_FFFF, 4'd15};
    tv[3] = '{OPCODE_JALR, FUNC3_ADD_SUB, 32'h1234_5678, 32'd1,
              32'hFFFF_FFFE, 4'd9, 32'h1234_5678, 32'd1, 4'd9};

    idle();
    bus.in_opcode = '0; bus.in_func3 = '0; bus.in_func1 = 0;
    bus.in_q1_rdy = 1; bus.in_q2_rdy = 1;
    bus.in_v1 = '0; bus.in_v2 = '0; bus.in_q1 = '0; bus.in_q2 = '0;
    bus.in_imm = '0; bus.in_off = '0; bus.in_pc = '0;
    bus.in_rob_target = '0; bus.in_is_c_extend = 0;
    bus.cdb_alu_rob = '0; bus.cdb_alu_data = '0;
    bus.cdb_lsb_rob = '0; bus.cdb_lsb_data = '0;
    m_clear();

    rst_n = 0;
    step();
    step();
    rst_n = 1;

    for (int i = 0; i < 4; i++) begin
      disp(tv[i].op, tv[i].f3, 1, tv[i].v1, 4'd0,
           1, tv[i].v2, 4'd0, tv[i].rob, tv[i].pc);
      step();
      chk("tv_no_issue_yet", 32'(bus.alu_inst_valid), 32'd0);
      idle();
      step();
      chk("tv_valid", 32'(bus.alu_inst_valid), 32'd1);
      chk("tv_data1", bus.alu_data1, tv[i].x_d1);
      chk("tv_data2", bus.alu_data2, tv[i].x_d2);
      chk("tv_rob", 32'(bus.alu_rob_target), 32'(tv[i].x_rob));
      chk("tv_op", 32'(bus.alu_opcode), 32'(tv[i].op));
      step();
      chk("tv_hold_data1", bus.alu_data1, tv[i].x_d1);
    end

    // wakeup through ALU CDB
    disp(OPCODE_ARITH, FUNC3_ADD_SUB, 0, 32'h0, 4'd6,
         1, 32'd3, 4'd0, 4'd4, 32'h40);
    step();
    idle();
    step();
    chk("wake_wait", 32'(bus.alu_inst_valid), 32'd0);
    cdb_alu(4'd6, 32'h10);
    step();
    chk("wake_capture_edge", 32'(bus.alu_inst_valid), 32'd0);
    idle();
    step();
    chk("wake_valid", 32'(bus.alu_inst_valid), 32'd1);
    chk("wake_data1", bus.alu_data1, 32'h10);

    // same-cycle forwarding from LSB CDB
    disp(OPCODE_ARITH, FUNC3_OR, 1, 32'd1, 4'd0,
         0, 32'h0, 4'd2, 4'd5, 32'h80);
    cdb_lsb(4'd2, 32'hABCD);
    step();
    idle();
    step();
    chk("fwd_valid", 32'(bus.alu_inst_valid), 32'd1);
    chk("fwd_data2", bus.alu_data2, 32'hABCD);

    // rdy low freezes everything
    disp(OPCODE_ARITH, FUNC3_AND, 1, 32'd9, 4'd0,
         1, 32'd9, 4'd0, 4'd8, 32'h90);
    rdy = 0;
    step();
    idle();
    step();
    chk("rdy_hold_valid", 32'(bus.alu_inst_valid), 32'd1);
    chk("rdy_hold_data2", bus.alu_data2, 32'hABCD);
    rdy = 1;
    step();

    // fill all slots, wake one
    for (int i = 0; i < N; i++) begin
      disp(OPCODE_ARITH, FUNC3_ADD_SUB, 0, 32'h0, 4'(i),
           1, 32'(i), 4'd0, 4'(i), 32'(i * 4));
      step();
    end
    idle();
    chk("full_set", 32'(bus.full), 32'd1);
    cdb_alu(4'd5, 32'h55);
    step();
    idle();
    step();
    chk("full_issue_rob", 32'(bus.alu_rob_target), 32'd5);
    chk("full_cleared", 32'(bus.full), 32'd0);
    disp(OPCODE_ARITH, FUNC3_SLL, 1, 32'd1, 4'd0,
         1, 32'd2, 4'd0, 4'd7, 32'h200);
    step();
    chk("full_again", 32'(bus.full), 32'd1);
    idle();
    step();
    chk("refill_rob", 32'(bus.alu_rob_target), 32'd7);
    flush();
    chk("flush_full", 32'(bus.full), 32'd0);

    // rollback drops held entries
    for (int i = 3; i < 6; i++) begin
      disp(OPCODE_ARITH, FUNC3_ADD_SUB, 0, 32'h0, 4'(i),
           1, 32'd0, 4'd0, 4'(i), 32'h300);
      step();
    end
    flush();
    chk("rb_full", 32'(bus.full), 32'd0);
    chk("rb_valid", 32'(bus.alu_inst_valid), 32'd0);
    chk("rb_data1", bus.alu_data1, 32'd0);
    cdb_alu(4'd3, 32'h1); cdb_lsb(4'd4, 32'h2);
    step();
    idle(); cdb_alu(4'd5, 32'h3);
    step();
    idle();
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rb_no_issue", 32'(bus.alu_inst_valid), 32'd0);
    end

    // select order: A older in slot 2, B younger in slot 0
    disp(OPCODE_ARITH, 3'd0, 0, 32'h0, 4'd1, 1, 32'h0, 4'd0, 4'd1, 32'h10);
    step();
    disp(OPCODE_ARITH, 3'd0, 0, 32'h0, 4'd2, 1, 32'h0, 4'd0, 4'd2, 32'h14);
    step();
    disp(OPCODE_ARITH, 3'd0, 0, 32'h0, 4'd9, 1, 32'h0, 4'd0, 4'hA, 32'h18);
    step();
    idle(); cdb_alu(4'd1, 32'h11);
    step();
    idle();
    step();
    disp(OPCODE_ARITH, 3'd0, 0, 32'h0, 4'd10, 1, 32'h0, 4'd0, 4'hB, 32'h1C);
    step();
    idle(); cdb_alu(4'd9, 32'h99); cdb_lsb(4'd10, 32'hAA);
    step();
    idle();
`ifdef ALU_RS_OLDEST_FIRST_EN
    first_rob = 4'hA;
`else
    first_rob = 4'hB;
`endif
    step();
    chk("prio_first", 32'(bus.alu_rob_target), 32'(first_rob));
    step();
    chk("prio_second", 32'(bus.alu_rob_target), 32'(first_rob ^ 4'h1));
    flush();

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [3:0] t;
      idle();
      rdy = ($urandom_range(0, 9) != 0);
      rollback = ($urandom_range(0, 79) == 0);
      if (m_cnt() < N && $urandom_range(0, 2) != 0)
        disp(7'($urandom), 3'($urandom), 1'($urandom), $urandom,
             4'($urandom), 1'($urandom), $urandom, 4'($urandom),
             4'($urandom), $urandom);
      if ($urandom_range(0, 1) == 1)
        cdb_alu(4'($urandom), $urandom);
      t = 4'($urandom);
      if ($urandom_range(0, 2) == 0 &&
          !(bus.cdb_alu_valid && bus.cdb_alu_rob == t))
        cdb_lsb(t, $urandom);
      step();
      rollback = 0;
    end
    rdy = 1;
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
